dct_1d_par: RTL and testbench
=============================

DCT_1D_PAR -- requirements
Module: dct_1d_par

Interface
REQ-001 SHALL have parameter IN_W, default 8, meaning input sample width (unsigned pixel).
REQ-002 SHALL have parameter OUT_W, default 10, meaning signed coefficient output width.
REQ-003 SHALL have parameter COEF_W, default 12, meaning signed cosine-coefficient width; the coefficient scale is 2^(COEF_W-2).
REQ-004 SHALL have ports clk (in, 1, clock) and rst (in, 1, reset); one clock, reset asynchronous and active-low.
REQ-005 SHALL have port enb (in, 1), meaning data_in valid this cycle; gaps are allowed.
REQ-006 SHALL have port data_in (in, IN_W), meaning pixel sample x[n], n = 0..7 in arrival order.
REQ-007 SHALL have port lvl_shift (in, 1), meaning subtract 2^(IN_W-1) from each sample; sampled with each accepted sample.
REQ-008 SHALL have port clr (in, 1), meaning synchronous flush of the partial input block.
REQ-009 SHALL have port data_out (out, OUT_W), meaning coefficient y[k], two's complement.
REQ-010 SHALL have port tp_enb (out, 1), meaning data_out valid (transpose-buffer write enable).
REQ-011 SHALL have port blk_last (out, 1), meaning the current data_out is y[7].

Function
REQ-012 SHALL compute the orthonormal 8-point DCT-II: y[k] = sum over n of C[k][n]*x[n], with C[k][n] = round(2^(COEF_W-2) * c(k)/2 * cos((2n+1)k*pi/16)), where c(0) = 1/sqrt2 and c(k>0) = 1.
REQ-013 SHALL hold eight parallel accumulators and add x*C[k][in_cnt] to all eight on each cycle with enb=1; the accumulator width SHALL be IN_W+1+COEF_W+3 bits.
REQ-014 SHALL hold a 3-bit in_cnt that increments on each enb=1 cycle and wraps 7->0; when in_cnt==0, accumulators SHALL start from zero.
REQ-015 SHALL, on the edge accepting x[7], load all eight final sums into an output bank and clear the accumulators.
REQ-016 SHALL round each output as (sum + 2^(COEF_W-3)) >>> (COEF_W-2), with arithmetic shift.
REQ-017 SHALL register data_out and present y[0]..y[7] on eight consecutive cycles.
REQ-018 SHALL drive y[0] in the cycle following the edge that accepted x[7]; latency is one cycle.
REQ-019 SHALL assert tp_enb for exactly those eight cycles, and assert blk_last with y[7].
REQ-020 SHALL drive data_out = 0 whenever tp_enb = 0.
REQ-021 SHALL, for back-to-back blocks (enb held high), keep tp_enb continuously high with no bubble; a new bank load coincides with the cycle after y[7].
REQ-022 SHALL, on clr=1, reset in_cnt and the accumulators; clr has priority over a simultaneous enb.
REQ-023 SHALL NOT let clr affect an output burst already in progress.
REQ-024 SHALL make input gaps (enb=0) stretch only block accumulation; outputs are never stalled.

Reset
REQ-025 SHALL, on rst=0 asynchronously, clear in_cnt, the accumulators, the output bank and the output counter, and drive data_out=0, tp_enb=0, blk_last=0.
REQ-026 SHALL, on reset mid-block or mid-burst, discard all partial data; the first block after release begins with the next enb=1 sample.

Configuration
REQ-027 SHALL, with macro DCT1D_SAT_EN defined, saturate rounded results to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
REQ-028 SHALL, without DCT1D_SAT_EN, truncate rounded results to their low OUT_W bits (wrap).

Structure
REQ-029 SHALL place the coefficient-table function, the default widths and the block length constant (8) in shared package dct_pkg.
REQ-030 SHALL implement the coefficient lookup (row select by in_cnt, all eight k in parallel) as sub-module dct_coef_rom.

Verification
REQ-031 SHALL verify: lvl_shift=1, eight samples of 128 -> y0..y7 all 0, tp_enb high for 8 cycles, blk_last on the 8th.
REQ-032 SHALL verify: lvl_shift=1, eight samples of 255 -> y0=359, y1..y7=0; eight samples of 0 -> y0=-362.
REQ-033 SHALL verify: lvl_shift=0, eight samples of 255 -> y0=511 with DCT1D_SAT_EN, y0=-303 without.
REQ-034 SHALL verify: 3 blocks with enb held high -> tp_enb high for 24 contiguous cycles, first y0 one cycle after x[7].
REQ-035 SHALL verify: enb toggled 1/0 across a block -> same outputs as gap-free; clr after 5 samples -> no output, and the next 8 samples form a clean block.
REQ-036 SHALL verify: rst=0 during the 4th output of a burst -> tp_enb=0 and data_out=0 immediately; the following block is correct.

Source files
------------

// File: rtl/dct_pkg.sv
// Shared constants and cosine-table generator for the 8-point DCT-II datapath.
// Latency: n/a (constants and constant functions only).
// Backpressure: n/a.
package dct_pkg;

    localparam int DCT_N      = 8;
    localparam int DCT_IN_W   = 8;
    localparam int DCT_OUT_W  = 10;
    localparam int DCT_COEF_W = 12;

    // Reference cosine magnitudes are held at 2^24 and rounded down to the
    // requested coefficient scale, so COEF_W up to 26 is supported.
    localparam int DCT_COS_FRAC = 24;

    typedef logic [2:0] dct_idx_t;

    // 0.5 * cos(m*pi/16) scaled by 2^24, m = 0..8.
    function automatic int dct_half_cos(input int m);
        int v;
        case (m)
            0:       v = 8388608;
            1:       v = 8227423;
            2:       v = 7750063;
            3:       v = 6974873;
            4:       v = 5931642;
            5:       v = 4660461;
            6:       v = 3210181;
            7:       v = 1636536;
            default: v = 0;
        endcase
        return v;
    endfunction

    // C[k][n] = round(2^(coef_w-2) * c(k)/2 * cos((2n+1)k*pi/16)).
    function automatic int dct_coef(input int k, input int n, input int coef_w);
        int m;
        int mag;
        int sh;
        int q;
        logic neg;
        m   = ((2 * n + 1) * k) % 32;
        neg = 1'b0;
        if (m > 16) m = 32 - m;
        if (m > 8) begin
            m   = 16 - m;
            neg = 1'b1;
        end
        // c(0)/2 = 1/(2*sqrt2) coincides with 0.5*cos(pi/4).
        mag = (k == 0) ? dct_half_cos(4) : dct_half_cos(m);
        sh  = DCT_COS_FRAC - (coef_w - 2);
        q   = (mag + (1 << (sh - 1))) >>> sh;
        return neg ? -q : q;
    endfunction

endpackage

// File: rtl/dct_coef_rom.sv
// Cosine-coefficient column lookup: for sample index in_cnt, all eight C[k][in_cnt].
// Latency: combinational.
// Backpressure: none.
module dct_coef_rom
    import dct_pkg::*;
#(
    parameter int COEF_W = DCT_COEF_W
) (
    input  logic [2:0]                    in_cnt,
    output logic [DCT_N-1:0][COEF_W-1:0]  coef
);

    typedef logic [DCT_N-1:0][DCT_N-1:0][COEF_W-1:0] tbl_t;

    function automatic tbl_t build_tbl();
        tbl_t t;
        for (int n = 0; n < DCT_N; n++) begin
            for (int k = 0; k < DCT_N; k++) begin
                t[n][k] = COEF_W'(dct_coef(k, n, COEF_W));
            end
        end
        return t;
    endfunction

    localparam tbl_t TBL = build_tbl();

    assign coef = TBL[in_cnt];

endmodule

// File: rtl/dct_1d_par.sv
// 1-D 8-point DCT-II, eight parallel MACs; y[0..7] streamed out after each block of 8 samples.
// Latency: y[0] one cycle after the edge accepting x[7]. Optional macro DCT1D_SAT_EN saturates outputs.
// Backpressure: none; enb gaps only stretch accumulation, output bursts never stall.
module dct_1d_par
    import dct_pkg::*;
#(
    parameter int IN_W   = DCT_IN_W,
    parameter int OUT_W  = DCT_OUT_W,
    parameter int COEF_W = DCT_COEF_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enb,
    input  logic [IN_W-1:0]  data_in,
    input  logic             lvl_shift,
    input  logic             clr,
    output logic [OUT_W-1:0] data_out,
    output logic             tp_enb,
    output logic             blk_last
);

    localparam int ACC_W = IN_W + 1 + COEF_W + 3;
    localparam int SH    = COEF_W - 2;

    localparam logic signed [ACC_W-1:0] ZERO     = '0;
    localparam logic signed [ACC_W-1:0] RND_HALF = ACC_W'(2 ** (COEF_W - 3));
    localparam logic signed [IN_W:0]    LVL_OFS  = (IN_W + 1)'(2 ** (IN_W - 1));
`ifdef DCT1D_SAT_EN
    localparam logic signed [ACC_W-1:0] SAT_MAX  = ACC_W'(2 ** (OUT_W - 1) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN  = ~SAT_MAX;
`endif

    dct_idx_t                       in_cnt;
    dct_idx_t                       out_idx;
    logic signed [ACC_W-1:0]        acc     [DCT_N];
    logic signed [ACC_W-1:0]        acc_nxt [DCT_N];
    logic        [OUT_W-1:0]        res     [DCT_N];
    logic        [OUT_W-1:0]        bank    [DCT_N];
    logic [DCT_N-1:0][COEF_W-1:0]   coef;
    logic signed [IN_W:0]           smp;
    logic                           blk_done;

    function automatic logic [OUT_W-1:0] fit(input logic signed [ACC_W-1:0] s);
        logic signed [ACC_W-1:0] r;
        r = (s + RND_HALF) >>> SH;
`ifdef DCT1D_SAT_EN
        if (r > SAT_MAX) r = SAT_MAX;
        else if (r < SAT_MIN) r = SAT_MIN;
`endif
        return OUT_W'(r);
    endfunction

    dct_coef_rom #(
        .COEF_W (COEF_W)
    ) u_coef_rom (
        .in_cnt (in_cnt),
        .coef   (coef)
    );

    assign blk_done = enb && !clr && (in_cnt == 3'd7);

    // Accumulators restart from zero at the first sample of every block.
    always_comb begin
        smp = $signed({1'b0, data_in});
        if (lvl_shift) smp = smp - LVL_OFS;
        for (int k = 0; k < DCT_N; k++) begin
            acc_nxt[k] = ((in_cnt == 3'd0) ? ZERO : acc[k])
                       + ACC_W'(smp) * ACC_W'($signed(coef[k]));
            res[k]     = fit(acc_nxt[k]);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in_cnt <= '0;
            for (int k = 0; k < DCT_N; k++) acc[k] <= '0;
        end else if (clr) begin
            in_cnt <= '0;
            for (int k = 0; k < DCT_N; k++) acc[k] <= '0;
        end else if (enb) begin
            in_cnt <= in_cnt + 3'd1;
            for (int k = 0; k < DCT_N; k++) acc[k] <= blk_done ? ZERO : acc_nxt[k];
        end
    end

    // y[0] goes straight to data_out on the load edge; the bank feeds y[1..7].
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < DCT_N; k++) bank[k] <= '0;
            out_idx  <= '0;
            data_out <= '0;
            tp_enb   <= 1'b0;
            blk_last <= 1'b0;
        end else if (blk_done) begin
            for (int k = 0; k < DCT_N; k++) bank[k] <= res[k];
            out_idx  <= 3'd1;
            data_out <= res[0];
            tp_enb   <= 1'b1;
            blk_last <= 1'b0;
        end else if (tp_enb && !blk_last) begin
            out_idx  <= out_idx + 3'd1;
            data_out <= bank[out_idx];
            blk_last <= (out_idx == 3'd7);
        end else begin
            data_out <= '0;
            tp_enb   <= 1'b0;
            blk_last <= 1'b0;
        end
    end

endmodule

// File: tb/tb_dct_1d_par.sv
// Directed bench for dct_1d_par: vector table plus clr, gap, back-to-back and reset sequences.
module tb_dct_1d_par;

    localparam int IN_W   = 8;
    localparam int OUT_W  = 10;
    localparam int COEF_W = 12;
    localparam int NVEC   = 7;

`ifdef DCT1D_SAT_EN
    localparam int Y0_255 = 511;
`else
    localparam int Y0_255 = -303;
`endif

    typedef int arr8_t [8];

    typedef struct packed {
        logic             lvl;
        logic [7:0][7:0]  x;
        logic [7:0][15:0] y;
    } vec_t;

    typedef struct {
        int cyc;
        int dat;
        int last;
    } obs_t;

    logic             clk;
    logic             rst;
    logic             enb;
    logic [IN_W-1:0]  data_in;
    logic             lvl_shift;
    logic             clr;
    logic [OUT_W-1:0] data_out;
    logic             tp_enb;
    logic             blk_last;

    vec_t tbl [NVEC];
    obs_t obs_q [$];
    int   cyc       = 0;
    int   n_checks  = 0;
    int   n_err     = 0;
    int   zero_viol = 0;
    int   last_cyc  = 0;

    dct_1d_par #(
        .IN_W   (IN_W),
        .OUT_W  (OUT_W),
        .COEF_W (COEF_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .enb       (enb),
        .data_in   (data_in),
        .lvl_shift (lvl_shift),
        .clr       (clr),
        .data_out  (data_out),
        .tp_enb    (tp_enb),
        .blk_last  (blk_last)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        obs_t o;
        if (tp_enb) begin
            o.cyc  = cyc;
            o.dat  = int'($signed(data_out));
            o.last = int'(blk_last);
            obs_q.push_back(o);
        end else if (data_out != '0 || blk_last) begin
            zero_viol++;
        end
    end

    task automatic check(input string nm, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic lvl, input int fill, input int pos,
                                input int val, input arr8_t y);
        vec_t r;
        r.lvl = lvl;
        for (int i = 0; i < 8; i++) begin
            r.x[i] = (i == pos) ? 8'(val) : 8'(fill);
            r.y[i] = 16'(y[i]);
        end
        return r;
    endfunction

    task automatic send(input int vi, input bit gaps);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            enb       = 1'b1;
            data_in   = tbl[vi].x[i];
            lvl_shift = tbl[vi].lvl;
            last_cyc  = cyc;
            if (gaps && i < 7) begin
                @(negedge clk);
                enb = 1'b0;
            end
        end
    endtask

    // Expect nblk bursts from tbl[first_vec..], contiguous, starting at cycle first_cyc.
    task automatic check_burst(input int first_vec, input int nblk, input int first_cyc,
                               input string nm);
        @(negedge clk);
        enb     = 1'b0;
        data_in = '0;
        repeat (8 * nblk + 4) @(negedge clk);
        check({nm, "_cnt"}, obs_q.size(), 8 * nblk);
        if (obs_q.size() == 8 * nblk) begin
            for (int i = 0; i < 8 * nblk; i++) begin
                check($sformatf("%s_y%0d", nm, i), obs_q[i].dat,
                      int'($signed(tbl[first_vec + i / 8].y[i % 8])));
                check($sformatf("%s_last%0d", nm, i), obs_q[i].last, int'((i % 8) == 7));
                check($sformatf("%s_cyc%0d", nm, i), obs_q[i].cyc, first_cyc + i);
            end
        end
    endtask

    initial begin
        arr8_t yt;
        int    first;

        yt = '{0, 0, 0, 0, 0, 0, 0, 0};
        tbl[0] = mk(1'b1, 128, -1, 0, yt);
        yt = '{359, 0, 0, 0, 0, 0, 0, 0};
        tbl[1] = mk(1'b1, 255, -1, 0, yt);
        yt = '{-362, 0, 0, 0, 0, 0, 0, 0};
        tbl[2] = mk(1'b1, 0, -1, 0, yt);
        yt = '{Y0_255, 0, 0, 0, 0, 0, 0, 0};
        tbl[3] = mk(1'b0, 255, -1, 0, yt);
        yt = '{35, 49, 46, 42, 35, 28, 19, 10};
        tbl[4] = mk(1'b0, 0, 0, 100, yt);
        yt = '{71, -98, 92, -83, 71, -55, 38, -20};
        tbl[5] = mk(1'b0, 0, 7, 200, yt);
        yt = '{23, 18, -12, -31, -23, 6, 30, 27};
        tbl[6] = mk(1'b0, 0, 2, 64, yt);

        rst       = 1'b0;
        enb       = 1'b0;
        data_in   = '0;
        lvl_shift = 1'b0;
        clr       = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_tp_enb", int'(tp_enb), 0);
        check("rst_data_out", int'(data_out), 0);
        check("rst_blk_last", int'(blk_last), 0);
        rst = 1'b1;

        for (int v = 0; v < NVEC; v++) begin
            obs_q.delete();
            send(v, 1'b0);
            check_burst(v, 1, last_cyc + 1, $sformatf("vec%0d", v));
        end

        obs_q.delete();
        send(5, 1'b1);
        check_burst(5, 1, last_cyc + 1, "gaps");

        obs_q.delete();
        send(4, 1'b0);
        first = last_cyc;
        send(5, 1'b0);
        send(6, 1'b0);
        check_burst(4, 3, first + 1, "b2b");

        // Partial block flushed by clr, with clr colliding with a valid sample.
        obs_q.delete();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            enb       = 1'b1;
            data_in   = 8'd255;
            lvl_shift = 1'b0;
        end
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        enb = 1'b0;
        repeat (12) @(negedge clk);
        check("clr_no_out", obs_q.size(), 0);
        send(4, 1'b0);
        check_burst(4, 1, last_cyc + 1, "clr_next");

        // clr during an output burst must not disturb it.
        obs_q.delete();
        send(5, 1'b0);
        @(negedge clk);
        enb = 1'b0;
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check_burst(5, 1, last_cyc + 1, "clr_burst");

        // Reset while the 4th coefficient is on the output.
        obs_q.delete();
        send(4, 1'b0);
        @(negedge clk);
        enb = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_rst_y3", int'($signed(data_out)), 42);
        rst = 1'b0;
        #1;
        check("mid_rst_tp_enb", int'(tp_enb), 0);
        check("mid_rst_data_out", int'(data_out), 0);
        check("mid_rst_blk_last", int'(blk_last), 0);
        @(negedge clk);
        enb     = 1'b1;
        data_in = 8'd200;
        repeat (2) @(negedge clk);
        enb = 1'b0;
        rst = 1'b1;
        obs_q.delete();
        send(5, 1'b0);
        check_burst(5, 1, last_cyc + 1, "post_rst");

        check("idle_zero", zero_viol, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
